mm2im_accumulator: RTL and testbench

//  Consumer of the MM2IM mapper: takes one mapped row (cmap, omap_flat) plus 16 PE partial sums.

---
 rtl/mm2im_accumulator.sv | 164 ++++++++++++++++
 tb/tb_mm2im_accumulator.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm2im_accumulator.sv
// MM2IM accumulator: serialises one mapped row of PE partial sums through a 3-stage
// read-modify-write pipeline into 16 accumulator BRAMs. Optional clamp: ACC_SATURATE_EN.
module mm2im_accumulator #(
    parameter int NUM_PE = 16,
    parameter int PSUM_W = 16,
    parameter int ACC_W  = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     map_valid,
    output logic                     map_ready,
    input  logic [NUM_PE-1:0]        cmap,
    input  logic [NUM_PE*14-1:0]     omap_flat,
    input  logic [NUM_PE*PSUM_W-1:0] psum_flat,
    output logic [15:0]              acc_rd_en,
    output logic [9:0]               acc_rd_addr,
    input  logic [16*ACC_W-1:0]      acc_rd_data_flat,
    output logic [15:0]              acc_wr_en,
    output logic [9:0]               acc_wr_addr,
    output logic [ACC_W-1:0]         acc_wr_data,
    output logic                     acc_idle,
    output logic [15:0]              wr_count
`ifdef ACC_SATURATE_EN
    ,
    output logic                     sat_flag
`endif
);

    localparam int IDX_W = $clog2(NUM_PE);

    typedef enum logic {S_IDLE, S_SCAN} state_t;

    state_t                     state;
    logic [NUM_PE-1:0]          mask_q;
    logic [NUM_PE*14-1:0]       omap_q;
    logic [NUM_PE*PSUM_W-1:0]   psum_q;

    logic                       s0_v, s1_v, s2_v, w_v;
    logic [13:0]                s0_key, s1_key, s2_key, w_key;
    logic [PSUM_W-1:0]          s0_psum, s1_psum;
    logic [ACC_W-1:0]           s2_sum, w_sum;

    logic [IDX_W-1:0]           pick;
    logic [13:0]                pick_key;
    logic [PSUM_W-1:0]          pick_psum;
    logic [ACC_W-1:0]           operand;
    logic [ACC_W-1:0]           sum;
`ifdef ACC_SATURATE_EN
    logic [ACC_W:0]             sum_wide;
    logic                       overflow;
`endif

    // Lowest-index remaining entry wins: scan high to low so the last hit is the lowest.
    always_comb begin
        pick = '0;
        for (int unsigned i = 0; i < NUM_PE; i++) begin
            if (mask_q[NUM_PE-1-i]) pick = IDX_W'(NUM_PE-1-i);
        end
        pick_key  = omap_q[int'(pick)*14 +: 14];
        pick_psum = psum_q[int'(pick)*PSUM_W +: PSUM_W];
    end

    // S1 operand: the write in flight (S2) is newest, then the one just written (W),
    // which the read-first BRAM returned as stale data.
    always_comb begin
        operand = acc_rd_data_flat[int'(s1_key[13:10])*ACC_W +: ACC_W];
        if (s2_v && s2_key == s1_key)
            operand = s2_sum;
        else if (w_v && w_key == s1_key)
            operand = w_sum;
    end

`ifdef ACC_SATURATE_EN
    always_comb begin
        sum_wide = {operand[ACC_W-1], operand}
                 + {{(ACC_W+1-PSUM_W){s1_psum[PSUM_W-1]}}, s1_psum};
        overflow = sum_wide[ACC_W] != sum_wide[ACC_W-1];
        sum      = sum_wide[ACC_W-1:0];
        if (overflow)
            sum = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
`else
    always_comb begin
        sum = operand + {{(ACC_W-PSUM_W){s1_psum[PSUM_W-1]}}, s1_psum};
    end
`endif

    assign acc_rd_en   = s0_v ? (16'b1 << s0_key[13:10]) : '0;
    assign acc_rd_addr = s0_key[9:0];
    assign acc_wr_en   = s2_v ? (16'b1 << s2_key[13:10]) : '0;
    assign acc_wr_addr = s2_key[9:0];
    assign acc_wr_data = s2_sum;
    assign acc_idle    = (state == S_IDLE) && !s0_v && !s1_v && !s2_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            map_ready <= 1'b0;
            mask_q    <= '0;
            omap_q    <= '0;
            psum_q    <= '0;
            s0_v      <= 1'b0;
            s0_key    <= '0;
            s0_psum   <= '0;
            s1_v      <= 1'b0;
            s1_key    <= '0;
            s1_psum   <= '0;
            s2_v      <= 1'b0;
            s2_key    <= '0;
            s2_sum    <= '0;
            w_v       <= 1'b0;
            w_key     <= '0;
            w_sum     <= '0;
            wr_count  <= '0;
`ifdef ACC_SATURATE_EN
            sat_flag  <= 1'b0;
`endif
        end else begin
            s1_v    <= s0_v;
            s1_key  <= s0_key;
            s1_psum <= s0_psum;
            s2_v    <= s1_v;
            s2_key  <= s1_key;
            s2_sum  <= sum;
            w_v     <= s2_v;
            w_key   <= s2_key;
            w_sum   <= s2_sum;
            if (s2_v) wr_count <= wr_count + 16'd1;
`ifdef ACC_SATURATE_EN
            if (s1_v && overflow) sat_flag <= 1'b1;
`endif
            s0_v <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (map_valid && map_ready) begin
                        mask_q    <= cmap;
                        omap_q    <= omap_flat;
                        psum_q    <= psum_flat;
                        state     <= S_SCAN;
                        map_ready <= 1'b0;
                    end else begin
                        map_ready <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (mask_q != '0) begin
                        s0_v         <= 1'b1;
                        s0_key       <= pick_key;
                        s0_psum      <= pick_psum;
                        mask_q[pick] <= 1'b0;
                    end else begin
                        state     <= S_IDLE;
                        map_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    map_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mm2im_accumulator.sv
// Directed self-checking bench for mm2im_accumulator with a behavioural read-first BRAM bank.
module tb_mm2im_accumulator;

    logic           clk = 1'b0;
    logic           rst;
    logic           map_valid;
    logic           map_ready;
    logic [15:0]    cmap;
    logic [223:0]   omap_flat;
    logic [255:0]   psum_flat;
    logic [15:0]    acc_rd_en;
    logic [9:0]     acc_rd_addr;
    logic [383:0]   acc_rd_data_flat = '0;
    logic [15:0]    acc_wr_en;
    logic [9:0]     acc_wr_addr;
    logic [23:0]    acc_wr_data;
    logic           acc_idle;
    logic [15:0]    wr_count;
`ifdef ACC_SATURATE_EN
    logic           sat_flag;
`endif

    mm2im_accumulator #(.NUM_PE(16), .PSUM_W(16), .ACC_W(24)) dut (
        .clk(clk), .rst(rst), .map_valid(map_valid), .map_ready(map_ready),
        .cmap(cmap), .omap_flat(omap_flat), .psum_flat(psum_flat),
        .acc_rd_en(acc_rd_en), .acc_rd_addr(acc_rd_addr), .acc_rd_data_flat(acc_rd_data_flat),
        .acc_wr_en(acc_wr_en), .acc_wr_addr(acc_wr_addr), .acc_wr_data(acc_wr_data),
        .acc_idle(acc_idle), .wr_count(wr_count)
`ifdef ACC_SATURATE_EN
        , .sat_flag(sat_flag)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [23:0] mem [16][1024];
    logic        mem_clr = 1'b0;
    logic        pre_en = 1'b0;
    logic [3:0]  pre_bank = '0;
    logic [9:0]  pre_addr = '0;
    logic [23:0] pre_data = '0;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int b = 0; b < 16; b++)
                for (int a = 0; a < 1024; a++)
                    mem[b][a] <= '0;
        end else begin
            for (int b = 0; b < 16; b++) begin
                if (acc_rd_en[b]) acc_rd_data_flat[b*24 +: 24] <= mem[b][acc_rd_addr];
                if (acc_wr_en[b]) mem[b][acc_wr_addr] <= acc_wr_data;
            end
            if (pre_en) mem[pre_bank][pre_addr] <= pre_data;
        end
    end

    typedef struct {
        int          cyc;
        logic [15:0] en;
        logic [9:0]  addr;
        logic [23:0] data;
    } ev_t;
    ev_t rdq[$];
    ev_t wrq[$];

    always @(negedge clk) begin
        if (acc_rd_en != '0) rdq.push_back('{cyc, acc_rd_en, acc_rd_addr, 24'd0});
        if (acc_wr_en != '0) wrq.push_back('{cyc, acc_wr_en, acc_wr_addr, acc_wr_data});
    end

    int errors = 0;
    int checks = 0;
    int t_cap  = 0;
    int t_a    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_row();
        cmap      = '0;
        omap_flat = '1;
        for (int i = 0; i < 16; i++) psum_flat[i*16 +: 16] = 16'($urandom);
        rdq.delete();
        wrq.delete();
    endtask

    task automatic set_entry(input int i, input logic [3:0] id, input logic [9:0] addr,
                             input logic [15:0] ps);
        omap_flat[i*14 +: 14] = {id, addr};
        psum_flat[i*16 +: 16] = ps;
        cmap[i]               = 1'b1;
    endtask

    // Waits (bounded) for map_ready, presents the row for one edge, then scrambles the inputs.
    task automatic capture();
        int n;
        n = 0;
        while (!map_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ready_wait", {31'd0, map_ready}, 32'd1);
        map_valid = 1'b1;
        @(posedge clk);
        #1;
        t_cap     = cyc;
        map_valid = 1'b0;
        cmap      = 16'($urandom);
        omap_flat = '0;
        for (int i = 0; i < 16; i++) psum_flat[i*16 +: 16] = 16'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [23:0] t4_exp [1:6];
        logic [23:0] t4b_exp [7];
        logic [23:0] t6_exp;

        rst       = 1'b1;
        map_valid = 1'b0;
        cmap      = '0;
        omap_flat = '1;
        psum_flat = '0;
        mem_clr   = 1'b1;
        step(1);
        mem_clr   = 1'b0;
        step(2);
        chk("rst_ready", {31'd0, map_ready}, 32'd0);
        chk("rst_rd_en", {16'd0, acc_rd_en}, 32'd0);
        chk("rst_wr_en", {16'd0, acc_wr_en}, 32'd0);
        chk("rst_idle", {31'd0, acc_idle}, 32'd1);
        chk("rst_wr_count", {16'd0, wr_count}, 32'd0);
        chk("rst_wr_data", {8'd0, acc_wr_data}, 32'd0);
`ifdef ACC_SATURATE_EN
        chk("rst_sat_flag", {31'd0, sat_flag}, 32'd0);
`endif
        rst = 1'b0;
        step(1);
        chk("rst_release_ready", {31'd0, map_ready}, 32'd1);

        // T2: single row, bank 0 addr 0..3, psum 1..4
        clear_row();
        for (int i = 0; i < 4; i++) set_entry(i, 4'd0, 10'(i), 16'(i + 1));
        capture();
        chk("t2_ready_at_T", {31'd0, map_ready}, 32'd0);
        chk("t2_idle_at_T", {31'd0, acc_idle}, 32'd0);
        for (int k = 1; k <= 8; k++) begin
            step(1);
            if (k == 4) chk("t2_ready_T4", {31'd0, map_ready}, 32'd0);
            if (k == 5) chk("t2_ready_T5", {31'd0, map_ready}, 32'd1);
            if (k == 6) chk("t2_idle_T6", {31'd0, acc_idle}, 32'd0);
            if (k == 7) chk("t2_idle_T7", {31'd0, acc_idle}, 32'd1);
        end
        chk("t2_nrd", rdq.size(), 32'd4);
        chk("t2_nwr", wrq.size(), 32'd4);
        if (rdq.size() == 4 && wrq.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t2_rd_cyc", rdq[i].cyc - t_cap, i + 1);
                chk("t2_rd_en", {16'd0, rdq[i].en}, 32'd1);
                chk("t2_rd_addr", {22'd0, rdq[i].addr}, i);
                chk("t2_wr_cyc", wrq[i].cyc - t_cap, i + 3);
                chk("t2_wr_en", {16'd0, wrq[i].en}, 32'd1);
                chk("t2_wr_addr", {22'd0, wrq[i].addr}, i);
                chk("t2_wr_data", {8'd0, wrq[i].data}, i + 1);
            end
        end
        chk("t2_wr_count", {16'd0, wr_count}, 32'd4);

        // T3: empty row
        clear_row();
        capture();
        chk("t3_ready_at_T", {31'd0, map_ready}, 32'd0);
        step(1);
        chk("t3_ready_T1", {31'd0, map_ready}, 32'd1);
        step(4);
        chk("t3_nrd", rdq.size(), 32'd0);
        chk("t3_nwr", wrq.size(), 32'd0);
        chk("t3_wr_count", {16'd0, wr_count}, 32'd4);

        // T4: overlapping back-to-back rows in bank 2
        clear_row();
        for (int i = 0; i < 4; i++) set_entry(i, 4'd2, 10'(i + 1), 16'd10);
        capture();
        t_a = t_cap;
        cmap      = '0;
        omap_flat = '1;
        for (int i = 0; i < 4; i++) set_entry(i, 4'd2, 10'(i + 3), 16'd5);
        capture();
        chk("t4_capture_gap", t_cap - t_a, 32'd6);
        step(10);
        t4_exp = '{24'd10, 24'd10, 24'd15, 24'd15, 24'd5, 24'd5};
        for (int a = 1; a <= 6; a++) chk("t4_mem", {8'd0, mem[2][a]}, {8'd0, t4_exp[a]});
        chk("t4_nwr", wrq.size(), 32'd8);
        chk("t4_wr_count", {16'd0, wr_count}, 32'd12);

        // T4b: same-row hazards exercising S2 and W forwarding and their priority
        clear_row();
        set_entry(0, 4'd3, 10'd7, 16'd1);
        set_entry(1, 4'd3, 10'd8, 16'hFFFE);
        set_entry(2, 4'd3, 10'd7, 16'd4);
        set_entry(3, 4'd3, 10'd7, 16'd8);
        set_entry(4, 4'd4, 10'd7, 16'd16);
        set_entry(5, 4'd4, 10'd7, 16'd32);
        set_entry(6, 4'd4, 10'd7, 16'd64);
        capture();
        step(12);
        t4b_exp = '{24'd1, 24'hFFFFFE, 24'd5, 24'd13, 24'd16, 24'd48, 24'd112};
        chk("t4b_nwr", wrq.size(), 32'd7);
        if (wrq.size() == 7)
            for (int i = 0; i < 7; i++) chk("t4b_wr_data", {8'd0, wrq[i].data}, {8'd0, t4b_exp[i]});
        chk("t4b_mem_3_7", {8'd0, mem[3][7]}, 32'd13);
        chk("t4b_mem_4_7", {8'd0, mem[4][7]}, 32'd112);
        chk("t4b_wr_count", {16'd0, wr_count}, 32'd19);

        // T5: sparse row, entries 0 and 15 only
        clear_row();
        set_entry(0, 4'd5, 10'd100, 16'd3);
        set_entry(15, 4'd15, 10'd1023, 16'hFFFF);
        capture();
        step(8);
        chk("t5_nrd", rdq.size(), 32'd2);
        if (rdq.size() == 2) begin
            chk("t5_rd0_cyc", rdq[0].cyc - t_cap, 32'd1);
            chk("t5_rd0_en", {16'd0, rdq[0].en}, 32'h0020);
            chk("t5_rd0_addr", {22'd0, rdq[0].addr}, 32'd100);
            chk("t5_rd1_cyc", rdq[1].cyc - t_cap, 32'd2);
            chk("t5_rd1_en", {16'd0, rdq[1].en}, 32'h8000);
            chk("t5_rd1_addr", {22'd0, rdq[1].addr}, 32'd1023);
        end
        chk("t5_nwr", wrq.size(), 32'd2);
        if (wrq.size() == 2) begin
            chk("t5_wr0_data", {8'd0, wrq[0].data}, 32'd3);
            chk("t5_wr1_en", {16'd0, wrq[1].en}, 32'h8000);
            chk("t5_wr1_data", {8'd0, wrq[1].data}, 32'hFFFFFF);
        end
        chk("t5_wr_count", {16'd0, wr_count}, 32'd21);

        // T6: overflow of the positive accumulator range
`ifdef ACC_SATURATE_EN
        chk("t6_sat_before", {31'd0, sat_flag}, 32'd0);
        t6_exp = 24'h7FFFFF;
`else
        t6_exp = 24'h807FEF;
`endif
        pre_en   = 1'b1;
        pre_bank = 4'd6;
        pre_addr = 10'd5;
        pre_data = 24'h7FFFF0;
        step(1);
        pre_en = 1'b0;
        clear_row();
        set_entry(0, 4'd6, 10'd5, 16'h7FFF);
        capture();
        step(8);
        chk("t6_nwr", wrq.size(), 32'd1);
        if (wrq.size() == 1) chk("t6_wr_data", {8'd0, wrq[0].data}, {8'd0, t6_exp});
        chk("t6_mem", {8'd0, mem[6][5]}, {8'd0, t6_exp});
`ifdef ACC_SATURATE_EN
        chk("t6_sat_flag", {31'd0, sat_flag}, 32'd1);
`endif
        chk("t6_wr_count", {16'd0, wr_count}, 32'd22);

        // T1: reset in the middle of a full row
        clear_row();
        for (int i = 0; i < 16; i++) set_entry(i, 4'd7, 10'(i), 16'd1);
        capture();
        step(3);
        rst = 1'b1;
        step(1);
        rdq.delete();
        wrq.delete();
        step(2);
        chk("t1_rd_en", {16'd0, acc_rd_en}, 32'd0);
        chk("t1_wr_en", {16'd0, acc_wr_en}, 32'd0);
        chk("t1_wr_count", {16'd0, wr_count}, 32'd0);
        chk("t1_idle", {31'd0, acc_idle}, 32'd1);
        chk("t1_ready_in_rst", {31'd0, map_ready}, 32'd0);
`ifdef ACC_SATURATE_EN
        chk("t1_sat_flag", {31'd0, sat_flag}, 32'd0);
`endif
        rst = 1'b0;
        step(1);
        chk("t1_ready_after", {31'd0, map_ready}, 32'd1);
        step(6);
        chk("t1_nrd_after", rdq.size(), 32'd0);
        chk("t1_nwr_after", wrq.size(), 32'd0);
        chk("t1_wr_count_after", {16'd0, wr_count}, 32'd0);
        chk("t1_idle_after", {31'd0, acc_idle}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
